// File: rtl/matrix_ls_responder_if.sv
// rtl/matrix_ls_responder_if.sv - request, memory and matrix-RF signal bundle for the LS responder
interface matrix_ls_responder_if #(
  parameter int ROWS   = 4,
  parameter int ROW_W  = 64,
  parameter int MREG_W = 4
);
  localparam int RW = $clog2(ROWS);

  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_ls;
  logic [MREG_W-1:0] req_rd;
  logic [31:0]       req_addr;
  logic [31:0]       req_stride;

  logic              mem_ren;
  logic              mem_wen;
  logic [31:0]       mem_addr;
  logic [ROW_W-1:0]  mem_wdata;
  logic [ROW_W-1:0]  mem_rdata;
  logic              mem_ready;

  logic              mrf_wen;
  logic [MREG_W-1:0] mrf_reg;
  logic [RW-1:0]     mrf_row;
  logic [ROW_W-1:0]  mrf_wdata;
  logic [ROW_W-1:0]  mrf_rdata;

  logic              done;
  logic [MREG_W-1:0] done_rd;

  modport slave (
    input  req_valid, req_ls, req_rd, req_addr, req_stride,
    input  mem_rdata, mem_ready, mrf_rdata,
    output req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
    output mrf_wen, mrf_reg, mrf_row, mrf_wdata, done, done_rd
  );

  modport master (
    output req_valid, req_ls, req_rd, req_addr, req_stride,
    output mem_rdata, mem_ready, mrf_rdata,
    input  req_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
    input  mrf_wen, mrf_reg, mrf_row, mrf_wdata, done, done_rd
  );
endinterface

// File: rtl/matrix_ls_responder.sv
// rtl/matrix_ls_responder.sv - sequences one matrix load/store as ROWS strided row accesses
module matrix_ls_responder #(
  parameter int ROWS   = 4,
  parameter int ROW_W  = 64,
  parameter int MREG_W = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  matrix_ls_responder_if.slave   bus
);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {IDLE, LOAD, STORE, DONE} state_e;

  state_e            state_q;
  logic [RW-1:0]     row_q, row_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       stride_q;
  logic [MREG_W-1:0] rd_q;

  logic xfer;
  logic last_row;

  assign xfer     = (state_q == LOAD) || (state_q == STORE);
  assign last_row = (row_q == RW'(ROWS - 1));
  assign row_d    = row_q + RW'(1);
  assign addr_d   = addr_q + stride_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      row_q    <= '0;
      addr_q   <= '0;
      stride_q <= '0;
      rd_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          // ls codes 0 and 3 complete the handshake but start nothing
          if (bus.req_valid && (bus.req_ls == 2'd1 || bus.req_ls == 2'd2)) begin
            rd_q     <= bus.req_rd;
            stride_q <= bus.req_stride;
            addr_q   <= bus.req_addr;
            row_q    <= '0;
            state_q  <= (bus.req_ls == 2'd1) ? LOAD : STORE;
          end
        end
        LOAD, STORE: begin
          if (bus.mem_ready) begin
            row_q  <= row_d;
            addr_q <= addr_d;
            if (last_row) state_q <= DONE;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.mem_ren   = (state_q == LOAD);
  assign bus.mem_wen   = (state_q == STORE);
  assign bus.mem_addr  = xfer ? addr_q : 32'd0;
  assign bus.mem_wdata = (state_q == STORE) ? bus.mrf_rdata : {ROW_W{1'b0}};

  // RF write fires in the same cycle the memory returns the row
  assign bus.mrf_wen   = (state_q == LOAD) && bus.mem_ready;
  assign bus.mrf_reg   = xfer ? rd_q : {MREG_W{1'b0}};
  assign bus.mrf_row   = xfer ? row_q : {RW{1'b0}};
  assign bus.mrf_wdata = (state_q == LOAD) ? bus.mem_rdata : {ROW_W{1'b0}};

  assign bus.done      = (state_q == DONE);
  assign bus.done_rd   = (state_q == DONE) ? rd_q : {MREG_W{1'b0}};
endmodule

// File: doc/matrix_ls_responder.md
Name: matrix_ls_responder

Overview:
- Scratchpad-side responder for the matrix load/store request that the matrix LS functional unit issues (op, destination matrix register, base address, stride).
- Sequences one matrix transfer as ROWS row-granular memory accesses at base + i*stride.
- Load: moves each memory row into the matrix register file. Store: moves each register row to memory.
- Emits a single-cycle done pulse back to the FU/scoreboard, tagged with the matrix register number.

Parameters:
- ROWS, 4, rows per matrix register (power of 2, >=2)
- ROW_W, 64, bits per row (4 x fp16)
- MREG_W, 4, matrix register index width (16 registers)

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- req_valid  in  1  FU presents request
- req_ready  out  1  responder can accept
- req_ls  in  2  0=none, 1=M_LOAD, 2=M_STORE
- req_rd  in  MREG_W  matrix register
- req_addr  in  32  base byte address
- req_stride  in  32  byte stride between rows
- mem_ren  out  1  memory read request
- mem_wen  out  1  memory write request
- mem_addr  out  32  row address
- mem_wdata  out  ROW_W  store data
- mem_rdata  in  ROW_W  load data, valid with mem_ready
- mem_ready  in  1  memory accepts/completes current access
- mrf_wen  out  1  matrix RF row write
- mrf_reg  out  MREG_W  RF register (read and write)
- mrf_row  out  log2(ROWS)  RF row (read and write)
- mrf_wdata  out  ROW_W  RF write data
- mrf_rdata  in  ROW_W  RF read data, combinational from mrf_reg/mrf_row
- done  out  1  transfer complete pulse
- done_rd  out  MREG_W  register of completed transfer

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset:
  - State=IDLE.
  - All outputs 0, except req_ready=1.
  - Row counter, address accumulator and latched request are cleared.
- Reset mid-transfer: abort immediately, no done, no further mem/mrf activity.
- FSM states: IDLE, LOAD, STORE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ls==1: latch rd/stride, set addr_acc=req_addr, row=0, go to LOAD next cycle.
  - On req_valid && req_ls==2: same latching, go to STORE.
  - req_ls==0 or 3 with valid: ignored, stay IDLE, no done.
  - Handshake: accept iff req_valid && req_ready.
- LOAD:
  - req_ready=0, mem_ren=1, mem_addr=addr_acc. Held stable until mem_ready.
  - Cycle with mem_ready=1: mrf_wen=1, mrf_reg=latched rd, mrf_row=row, mrf_wdata=mem_rdata (same cycle).
  - Then row+1 and addr_acc+=stride, both registered.
  - If row==ROWS-1, go to DONE instead.
- STORE:
  - mem_wen=1, mem_addr=addr_acc, mrf_reg=rd, mrf_row=row, mem_wdata=mrf_rdata.
  - Held until mem_ready, then advances exactly as LOAD. mrf_wen=0 throughout.
- DONE:
  - done=1 and done_rd=rd for exactly one cycle.
  - req_ready=0, then go to IDLE.
  - Minimum transfer = 1 (accept) + ROWS + 1 (done) cycles.
- Address arithmetic: 32-bit modulo 2^32, wrap-around silent.
  - stride=0 is legal: every row uses the same address.
  - No alignment checks.
- mem_ren and mem_wen are never both 1. Both are 0 outside LOAD/STORE.
- mem_ready while idle or in DONE is ignored.
- mrf_reg, mrf_row and mrf_wdata are 0 when not in LOAD/STORE.
- done_rd is 0 when done=0.
- Back-to-back requests: a new request can be accepted only in the cycle after DONE (IDLE).

Test Plan:
- Load, mem_ready always 1: ls=1, rd=5, addr=0x1000, stride=0x40 -> mem_addr 0x1000,0x1040,0x1080,0x10C0 on consecutive cycles; mrf writes reg 5 rows 0..3 with the returned data; done=1, done_rd=5 on cycle 6 after accept; req_ready low throughout.
- Store with stall: ls=2, rd=3, addr=0x2000, stride=8; mem_ready low 2 cycles per row -> addr/wdata held stable during stall; wdata equals RF reg 3 rows 0..3; done after 1+12+1 cycles; mrf_wen never 1.
- Wrap and zero stride: addr=0xFFFFFFF0, stride=0x10 -> addrs 0xFFFFFFF0,0x0,0x10,0x20. A second run with stride=0 -> all four rows use the same addr.
- Illegal/none op: req_valid with ls=0 and ls=3 -> req_ready stays 1, no mem/mrf activity, no done.
- Reset mid-load: assert RST after row 1 completes -> next cycle all outputs 0, req_ready=1, no done; a new load afterwards restarts at row 0.
- Back-to-back: second request held valid during a transfer -> not accepted until IDLE; accepted the cycle after done; done_rd matches each request in order.
